// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - PC and fetch stage for the 3BC processor instruction memory.
// Holds the PC, the instruction register and a RUN-cycle counter; applies jump, branch, stall and halt.
module inst_fetch #(
  parameter int AW   = 10,
  parameter int IW   = 9,
  parameter int OFFW = 8,
  parameter int CNTW = 16
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [AW-1:0]   StartAddr,
  output logic [AW-1:0]   InstAddress,
  input  logic [IW-1:0]   InstIn,
  output logic [IW-1:0]   Instr,
  output logic [AW-1:0]   InstPC,
  output logic            InstValid,
  input  logic            Stall,
  input  logic            JumpEn,
  input  logic [AW-1:0]   JumpTarget,
  input  logic            BranchEn,
  input  logic [OFFW-1:0] BranchOff,
  input  logic            HaltReq,
  output logic            Done,
  output logic [CNTW-1:0] CycleCt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t          state_q;
  logic [AW-1:0]   pc_q;
  logic [IW-1:0]   ir_q;
  logic [AW-1:0]   inst_pc_q;
  logic            valid_q;
  logic            done_q;
  logic [CNTW-1:0] cyc_q;

  logic [AW-1:0]   branch_tgt_d;
  logic            ctrl_live;

  // Branch offsets are relative to the instruction in IR, not to the fetch PC.
  assign branch_tgt_d = inst_pc_q + {{(AW-OFFW){BranchOff[OFFW-1]}}, BranchOff};
  assign ctrl_live    = (state_q == S_RUN) && valid_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      inst_pc_q <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      cyc_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_HALT: begin
          if (Start) begin
            state_q <= S_RUN;
            pc_q    <= StartAddr;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            cyc_q   <= '0;
          end
        end
        S_RUN: begin
          if (cyc_q != '1) cyc_q <= cyc_q + CNTW'(1);
          // Halt is honoured even while stalled; all other control waits for Stall to drop.
          if (ctrl_live && HaltReq) begin
            state_q <= S_HALT;
            done_q  <= 1'b1;
            valid_q <= 1'b0;
          end else if (!Stall) begin
            if (ctrl_live && JumpEn) begin
              pc_q    <= JumpTarget;
              valid_q <= 1'b0;
            end else if (ctrl_live && BranchEn) begin
              pc_q    <= branch_tgt_d;
              valid_q <= 1'b0;
            end else begin
              ir_q      <= InstIn;
              inst_pc_q <= pc_q;
              valid_q   <= 1'b1;
              pc_q      <= pc_q + AW'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign InstAddress = pc_q;
  assign Instr       = ir_q;
  assign InstPC      = inst_pc_q;
  assign InstValid   = valid_q;
  assign Done        = done_q;
  assign CycleCt     = cyc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch against a behavioural fetch model.
module tb_inst_fetch;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [9:0]  StartAddr;
  logic [9:0]  InstAddress;
  logic [8:0]  InstIn;
  logic [8:0]  Instr;
  logic [9:0]  InstPC;
  logic        InstValid;
  logic        Stall;
  logic        JumpEn;
  logic [9:0]  JumpTarget;
  logic        BranchEn;
  logic [7:0]  BranchOff;
  logic        HaltReq;
  logic        Done;
  logic [15:0] CycleCt;

  logic [8:0] mem [0:1023];

  int         m_st;
  logic [9:0] m_pc, m_ipc;
  logic [8:0] m_ir;
  logic       m_v, m_done;
  int         m_cyc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  assign InstIn = mem[InstAddress];

  inst_fetch dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
    .InstAddress(InstAddress), .InstIn(InstIn), .Instr(Instr), .InstPC(InstPC),
    .InstValid(InstValid), .Stall(Stall), .JumpEn(JumpEn), .JumpTarget(JumpTarget),
    .BranchEn(BranchEn), .BranchOff(BranchOff), .HaltReq(HaltReq), .Done(Done),
    .CycleCt(CycleCt)
  );

  task automatic model_reset();
    m_st = 0; m_pc = '0; m_ir = '0; m_ipc = '0; m_v = 1'b0; m_done = 1'b0; m_cyc = 0;
  endtask

  // Drive one cycle of inputs, advance the reference model, then sample 1 time unit after the edge.
  task automatic tick(input logic st, input logic [9:0] sa, input logic stl, input logic je,
                      input logic [9:0] jt, input logic be, input logic [7:0] bo, input logic hr);
    Start = st; StartAddr = sa; Stall = stl; JumpEn = je; JumpTarget = jt;
    BranchEn = be; BranchOff = bo; HaltReq = hr;
    if (m_st != 1) begin
      if (st) begin m_st = 1; m_pc = sa; m_v = 1'b0; m_cyc = 0; m_done = 1'b0; end
    end else begin
      if (m_cyc < 65535) m_cyc = m_cyc + 1;
      if (m_v && hr) begin
        m_st = 2; m_done = 1'b1; m_v = 1'b0;
      end else if (!stl) begin
        if (m_v && je) begin
          m_pc = jt; m_v = 1'b0;
        end else if (m_v && be) begin
          m_pc = 10'((int'(m_ipc) + int'($signed(bo)) + 1024) % 1024); m_v = 1'b0;
        end else begin
          m_ir = mem[m_pc]; m_ipc = m_pc; m_v = 1'b1; m_pc = 10'((int'(m_pc) + 1) % 1024);
        end
      end
    end
    @(posedge Clk); #1;
    Start = 1'b0; Stall = 1'b0; JumpEn = 1'b0; BranchEn = 1'b0; HaltReq = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 10'h0, 0, 0, 10'h0, 0, 8'h0, 0);
  endtask

  task automatic pulse_reset();
    @(negedge Clk); Reset = 1'b0;
    @(negedge Clk); Reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({Done, InstValid, Instr, InstPC, InstAddress, CycleCt} !== 56'h0) begin
      n_fail++; $display("FAIL reset_init: got %h want 0", {Done, InstValid, Instr, InstPC, InstAddress, CycleCt});
    end
    @(negedge Clk); Reset = 1'b1; model_reset();
    tick(1, 10'h155, 0, 0, 10'h0, 0, 8'h0, 0);
    idle(4);
    @(posedge Clk); #2; Reset = 1'b0; #1;
    n_checks++;
    if ({Done, InstValid, Instr, InstPC, InstAddress, CycleCt} !== 56'h0) begin
      n_fail++; $display("FAIL reset_async: got %h want 0", {Done, InstValid, Instr, InstPC, InstAddress, CycleCt});
    end
    @(negedge Clk); Reset = 1'b1; model_reset();
    tick(1, 10'h0, 0, 0, 10'h0, 0, 8'h0, 0);
    n_checks++;
    if ({InstValid, InstAddress, CycleCt} !== 27'h0) begin
      n_fail++; $display("FAIL start_state: got v=%b a=%h c=%0d want 0", InstValid, InstAddress, CycleCt);
    end
    for (int k = 0; k < 3; k++) begin
      idle(1);
      n_checks++;
      if (InstValid !== 1'b1 || InstPC !== 10'(k) || Instr !== mem[k] || CycleCt !== 16'(k + 1)) begin
        n_fail++; $display("FAIL start_seq%0d: got v=%b pc=%h ir=%h c=%0d want 1 %h %h %0d",
                           k, InstValid, InstPC, Instr, CycleCt, 10'(k), mem[k], k + 1);
      end
    end
  endtask

  task automatic test_wrap();
    pulse_reset();
    tick(1, 10'd1020, 0, 0, 10'h0, 0, 8'h0, 0);
    for (int k = 0; k < 6; k++) begin
      idle(1);
      n_checks++;
      if (InstPC !== 10'((1020 + k) % 1024) || CycleCt !== 16'(k + 1)) begin
        n_fail++; $display("FAIL wrap%0d: got pc=%h c=%0d want %h %0d", k, InstPC, CycleCt, 10'((1020 + k) % 1024), k + 1);
      end
    end
  endtask

  task automatic test_jump();
    pulse_reset();
    tick(1, 10'h010, 0, 0, 10'h0, 0, 8'h0, 0);
    idle(1);
    n_checks++;
    if (InstPC !== 10'h010) begin n_fail++; $display("FAIL jump_ir: got %h want 010", InstPC); end
    tick(0, 10'h0, 0, 1, 10'h200, 0, 8'h0, 0);
    n_checks++;
    if (InstValid !== 1'b0 || InstAddress !== 10'h200) begin
      n_fail++; $display("FAIL jump_bubble: got v=%b a=%h want 0 200", InstValid, InstAddress);
    end
    idle(1);
    n_checks++;
    if (InstValid !== 1'b1 || InstPC !== 10'h200 || Instr !== mem[10'h200]) begin
      n_fail++; $display("FAIL jump_target: got v=%b pc=%h ir=%h want 1 200 %h", InstValid, InstPC, Instr, mem[10'h200]);
    end
  endtask

  task automatic test_branch();
    pulse_reset();
    tick(1, 10'h002, 0, 0, 10'h0, 0, 8'h0, 0);
    idle(1);
    tick(0, 10'h0, 0, 0, 10'h0, 1, 8'hFD, 0);
    n_checks++;
    if (InstValid !== 1'b0 || InstAddress !== 10'h3FF) begin
      n_fail++; $display("FAIL branch_back: got v=%b a=%h want 0 3ff", InstValid, InstAddress);
    end
    idle(1);
    n_checks++;
    if (InstValid !== 1'b1 || InstPC !== 10'h3FF) begin
      n_fail++; $display("FAIL branch_target: got v=%b pc=%h want 1 3ff", InstValid, InstPC);
    end
    tick(0, 10'h0, 0, 1, 10'h055, 1, 8'h05, 0);
    idle(1);
    n_checks++;
    if (InstPC !== 10'h055) begin n_fail++; $display("FAIL jump_over_branch: got %h want 055", InstPC); end
    tick(0, 10'h0, 0, 0, 10'h0, 1, 8'h00, 0);
    idle(1);
    n_checks++;
    if (InstValid !== 1'b1 || InstPC !== 10'h055 || InstAddress !== 10'h056) begin
      n_fail++; $display("FAIL branch_zero: got v=%b pc=%h a=%h want 1 055 056", InstValid, InstPC, InstAddress);
    end
  endtask

  task automatic test_stall();
    logic [9:0] e_ipc, e_pc;
    logic [8:0] e_ir;
    int         c0;
    e_ipc = m_ipc; e_pc = m_pc; e_ir = m_ir; c0 = m_cyc;
    for (int k = 0; k < 3; k++) begin
      tick(0, 10'h0, 1, 1, 10'h300, 0, 8'h0, 0);
      n_checks++;
      if (InstValid !== 1'b1 || InstPC !== e_ipc || Instr !== e_ir || InstAddress !== e_pc || CycleCt !== 16'(c0 + k + 1)) begin
        n_fail++; $display("FAIL stall_hold%0d: got v=%b pc=%h ir=%h a=%h c=%0d want 1 %h %h %h %0d",
                           k, InstValid, InstPC, Instr, InstAddress, CycleCt, e_ipc, e_ir, e_pc, c0 + k + 1);
      end
    end
    tick(0, 10'h0, 0, 1, 10'h300, 0, 8'h0, 0);
    idle(1);
    n_checks++;
    if (InstPC !== 10'h300 || InstAddress !== 10'h301) begin
      n_fail++; $display("FAIL stall_release: got pc=%h a=%h want 300 301", InstPC, InstAddress);
    end
    tick(0, 10'h0, 1, 0, 10'h0, 0, 8'h0, 1);
    n_checks++;
    if (Done !== 1'b1 || InstValid !== 1'b0 || InstAddress !== 10'h301) begin
      n_fail++; $display("FAIL halt_in_stall: got d=%b v=%b a=%h want 1 0 301", Done, InstValid, InstAddress);
    end
  endtask

  task automatic test_restart();
    int c_h;
    c_h = m_cyc;
    idle(2);
    n_checks++;
    if (Done !== 1'b1 || CycleCt !== 16'(c_h) || InstAddress !== 10'h301) begin
      n_fail++; $display("FAIL halt_hold: got d=%b c=%0d a=%h want 1 %0d 301", Done, CycleCt, InstAddress, c_h);
    end
    tick(1, 10'h100, 0, 0, 10'h0, 0, 8'h0, 0);
    n_checks++;
    if (Done !== 1'b0 || CycleCt !== 16'h0 || InstValid !== 1'b0) begin
      n_fail++; $display("FAIL restart: got d=%b c=%0d v=%b want 0 0 0", Done, CycleCt, InstValid);
    end
    idle(1);
    n_checks++;
    if (InstValid !== 1'b1 || InstPC !== 10'h100 || CycleCt !== 16'd1) begin
      n_fail++; $display("FAIL restart_first: got v=%b pc=%h c=%0d want 1 100 1", InstValid, InstPC, CycleCt);
    end
    tick(1, 10'h3AA, 0, 0, 10'h0, 0, 8'h0, 0);
    n_checks++;
    if (InstPC !== 10'h101 || InstAddress !== 10'h102) begin
      n_fail++; $display("FAIL start_in_run: got pc=%h a=%h want 101 102", InstPC, InstAddress);
    end
  endtask

  task automatic test_random();
    pulse_reset();
    for (int n = 0; n < 400; n++) begin
      tick(($urandom % 16) == 0, 10'($urandom), ($urandom % 4) == 0, ($urandom % 8) == 0,
           10'($urandom), ($urandom % 6) == 0, 8'($urandom), ($urandom % 40) == 0);
      n_checks++;
      if (Done !== m_done || InstValid !== m_v || InstAddress !== m_pc || CycleCt !== 16'(m_cyc)) begin
        n_fail++; $display("FAIL rand_ctl%0d: got d=%b v=%b a=%h c=%0d want %b %b %h %0d",
                           n, Done, InstValid, InstAddress, CycleCt, m_done, m_v, m_pc, m_cyc);
      end
      if (m_v) begin
        n_checks++;
        if (Instr !== m_ir || InstPC !== m_ipc) begin
          n_fail++; $display("FAIL rand_ir%0d: got ir=%h pc=%h want %h %h", n, Instr, InstPC, m_ir, m_ipc);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 9'($urandom);
    Reset = 1'b0; Start = 1'b0; StartAddr = '0; Stall = 1'b0; JumpEn = 1'b0; JumpTarget = '0;
    BranchEn = 1'b0; BranchOff = '0; HaltReq = 1'b0;
    model_reset();
    test_reset();
    test_wrap();
    test_jump();
    test_branch();
    test_stall();
    test_restart();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
